mem_dump_ctrl: RTL and testbench
================================

# mem_dump_ctrl

Sequencer that reads a range of words out of the `reg_file` data memory and streams them as bytes to the debug UART transmitter. Optionally it also bulk-clears the memory. It sits between the memory's read and write ports and the UART TX byte interface, and is driven by the debug unit's command decoder. It owns the memory address lines only while `busy` is high; the debug top muxes its address and write lines onto the memory using `busy`.

## Interface
Parameters:
- `B`, default 16: memory word width. Must be a multiple of 8.
- `W`, default 11: memory address width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle dump request; sampled only in IDLE.
- `base_addr` in W: first address to dump; latched on an accepted `start`.
- `last_addr` in W: last address to dump, inclusive; latched on an accepted `start`.
- `clear_start` in 1: one-cycle clear request; functional only with the macro.
- `mem_addr` out W: read address, connects to memory `r_addr`.
- `mem_data` in B: memory `r_data`; combinational read data.
- `mem_wr_en` out 1: memory write enable.
- `mem_w_addr` out W: memory write address.
- `mem_w_data` out B: memory write data.
- `tx_data` out 8: byte toward the UART.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: UART accepts the byte.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when an operation completes.

## Operation
- Derived constant `BYTES = B/8`.
- States and transitions:
  - IDLE → FETCH on `start`.
  - IDLE → CLEAR on `clear_start` (macro only).
  - FETCH → SEND.
  - SEND → FETCH or DONE.
  - CLEAR → DONE.
  - DONE → IDLE.
- IDLE behaviour:
  - `start` latches `addr ← base_addr` and `end ← last_addr`.
  - `start` and `clear_start` in the same cycle: `start` wins and `clear_start` is dropped.
  - `start` and `clear_start` outside IDLE are ignored; no queuing.
- FETCH:
  - `mem_addr = addr`.
  - Shift register `sh ← mem_data`, `byte_cnt ← 0`.
  - Lasts exactly one cycle.
- SEND:
  - `tx_valid = 1`, `tx_data = sh[7:0]`, so bytes go out least-significant first.
  - On `tx_valid & tx_ready`: `sh ← sh >> 8`, `byte_cnt++`.
  - On the handshake with `byte_cnt == BYTES-1`:
    - if `addr == end`, go to DONE;
    - else `addr ← addr + 1` (mod 2^W) and go to FETCH.
- Wrap-around: if `last_addr < base_addr`, addressing wraps from 2^W−1 to 0.
  - Word count is `((last_addr − base_addr) mod 2^W) + 1`.
  - `base_addr == last_addr` dumps exactly one word.
- DONE: `done = 1` for one cycle, then IDLE.
- `mem_wr_en` is 0 in every state except CLEAR.

## Timing
- Reset values (every output and register): state IDLE, `mem_addr = 0`, `tx_valid = 0`, `tx_data = 0`, `busy = 0`, `done = 0`, `mem_wr_en = 0`, `mem_w_addr = 0`, `mem_w_data = 0`.
- Reset mid-operation aborts on that clock edge:
  - the partially sent word is lost;
  - no `done` pulse is generated.
- `start` accepted at edge n: FETCH during cycle n+1, first `tx_valid` in cycle n+2.
- Per-word cost: 1 FETCH cycle plus `BYTES` handshakes. With `tx_ready` held at 1, that is `BYTES+1` cycles per word.
- TX handshake rules:
  - While `tx_valid & !tx_ready`, `tx_data` holds stable.
  - `tx_valid` never drops before the byte is accepted.
- `done` pulses the cycle after the final handshake.
- `busy` deasserts in the cycle after `done`.

## Configuration
- Macro: `MEM_DUMP_CLEAR_EN`.
- Defined:
  - `clear_start` in IDLE sets `addr ← 0` and enters CLEAR.
  - Each CLEAR cycle drives `mem_wr_en = 1`, `mem_w_addr = addr`, `mem_w_data = 0`, then increments `addr`.
  - After writing address 2^W−1, go to DONE. Total: 2^W write cycles.
- Undefined:
  - the CLEAR state is not compiled;
  - `clear_start` is ignored;
  - `mem_wr_en`, `mem_w_addr` and `mem_w_data` are tied to 0.

## Structure
- Shared package `mem_dump_pkg`:
  - state encodings IDLE, FETCH, SEND, CLEAR, DONE (3 bits);
  - the `BYTES` derivation.
- Natural sub-module: `word_serializer`.
  - Loads a B-bit word on a load strobe and emits `BYTES` bytes LSB-first with valid/ready.
  - Returns a `last_byte` flag to the FSM.
- The FSM, address counter and end register stay in `mem_dump_ctrl`.

## Test plan
All scenarios use B=16, W=4 and memory preloaded with `mem[i] = 16'hA0i0`.
- Single word: `start`, base=3, last=3, `tx_ready=1` → bytes 0x30, 0xA0, then one `done` pulse; total 4 cycles from `start` to `done`.
- Range: base=2, last=4 → byte sequence 20 A0 30 A0 40 A0; `done` once.
- Wrap: base=14, last=1 → 4 words dumped, addresses 14, 15, 0, 1 in that order.
- Backpressure: `tx_ready` low for 5 cycles mid-word → `tx_data` and `tx_valid` stable throughout; no byte lost or duplicated.
- Reset mid-dump: reset asserted during the second byte → next cycle IDLE, all outputs 0, no `done`; a fresh `start` then works normally.
- Clear (macro defined): `clear_start` → 16 consecutive `mem_wr_en` cycles, addresses 0..15 with data 0, then `done`; a simultaneous `start` with `clear_start` performs the dump only.

Source files
------------

// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: state encodings and byte-count helper shared by the memory dump sequencer
package mem_dump_pkg;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SEND  = 3'd2,
      CLEAR = 3'd3,
      DONE  = 3'd4
   } state_t;
   function automatic int bytes_of(input int b);
      return b / 8;
   endfunction
endpackage

// File: rtl/word_serializer.sv
// word_serializer: loads a B-bit word and emits it LSB-first as bytes over a valid/ready handshake
module word_serializer
   import mem_dump_pkg::*;
#(
   parameter int B = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [B-1:0] word,
   input  logic         tx_ready,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   output logic         last_byte
);
   localparam int BYTES = bytes_of(B);
   localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
   logic [B-1:0]  sh;
   logic [CW-1:0] cnt;
   assign tx_data = sh[7:0];
   assign last_byte = cnt == CW'(BYTES - 1);
   // after the final shift sh is all zero, so tx_data idles at 0
   always_ff @(posedge clk) begin
      if (reset) begin
         sh <= '0;
         cnt <= '0;
         tx_valid <= 1'b0;
      end else if (load) begin
         sh <= word;
         cnt <= '0;
         tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
         sh <= sh >> 8;
         cnt <= cnt + 1'b1;
         if (last_byte) tx_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: streams a memory address range out as UART bytes; MEM_DUMP_CLEAR_EN adds a bulk clear
module mem_dump_ctrl
   import mem_dump_pkg::*;
#(
   parameter int B = 16,
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] base_addr,
   input  logic [W-1:0] last_addr,
   input  logic         clear_start,
   output logic [W-1:0] mem_addr,
   input  logic [B-1:0] mem_data,
   output logic         mem_wr_en,
   output logic [W-1:0] mem_w_addr,
   output logic [B-1:0] mem_w_data,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         busy,
   output logic         done
);
   state_t       state;
   logic [W-1:0] addr;
   logic [W-1:0] end_addr;
   logic         last_byte;
   assign mem_addr = addr;
   assign busy = state != IDLE;
   assign done = state == DONE;
   word_serializer #(.B(B)) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (state == FETCH),
      .word      (mem_data),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .last_byte (last_byte)
   );
`ifdef MEM_DUMP_CLEAR_EN
   assign mem_wr_en = state == CLEAR;
   assign mem_w_addr = mem_wr_en ? addr : '0;
   assign mem_w_data = '0;
`else
   wire unused_clear = clear_start;
   assign mem_wr_en = 1'b0;
   assign mem_w_addr = '0;
   assign mem_w_data = '0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         addr <= '0;
         end_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr <= base_addr;
                  end_addr <= last_addr;
                  state <= FETCH;
               end
`ifdef MEM_DUMP_CLEAR_EN
               else if (clear_start) begin
                  addr <= '0;
                  state <= CLEAR;
               end
`endif
            end
            FETCH: state <= SEND;
            SEND: begin
               if (tx_valid && tx_ready && last_byte) begin
                  if (addr == end_addr) begin
                     state <= DONE;
                  end else begin
                     addr <= addr + 1'b1;
                     state <= FETCH;
                  end
               end
            end
`ifdef MEM_DUMP_CLEAR_EN
            CLEAR: begin
               addr <= addr + 1'b1;
               if (&addr) state <= DONE;
            end
`endif
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb_mem_dump_ctrl: directed and randomized dumps checked against a byte-stream model of the memory
module tb_mem_dump_ctrl;
   localparam int B = 16;
   localparam int W = 4;
   logic         clk = 0;
   logic         reset = 1;
   logic         start = 0;
   logic         clear_start = 0;
   logic         tx_ready = 0;
   logic         reload = 1;
   logic [W-1:0] base_addr = 0;
   logic [W-1:0] last_addr = 0;
   logic [W-1:0] mem_addr;
   logic [B-1:0] mem_data;
   logic         mem_wr_en;
   logic [W-1:0] mem_w_addr;
   logic [B-1:0] mem_w_data;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         busy;
   logic         done;
   logic [B-1:0] mem [16];
   logic [B-1:0] model [16];
   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   mem_dump_ctrl #(.B(B), .W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .last_addr   (last_addr),
      .clear_start (clear_start),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_wr_en   (mem_wr_en),
      .mem_w_addr  (mem_w_addr),
      .mem_w_data  (mem_w_data),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .done        (done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (reload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'(32'hA000 + i * 16);
      end else if (mem_wr_en) begin
         mem[mem_w_addr] <= mem_w_data;
      end
   end
   assign mem_data = mem[mem_addr];
   always @(negedge clk) if (mem_wr_en) wr_cnt <= wr_cnt + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 16; i++) model[i] = 16'(32'hA000 + i * 16);
   endtask
   task automatic check_idle(input string tag);
      chk($sformatf("%s busy", tag), busy, 0);
      chk($sformatf("%s done", tag), done, 0);
      chk($sformatf("%s tx_valid", tag), tx_valid, 0);
      chk($sformatf("%s tx_data", tag), tx_data, 0);
      chk($sformatf("%s mem_addr", tag), mem_addr, 0);
      chk($sformatf("%s wr_en", tag), mem_wr_en, 0);
      chk($sformatf("%s w_addr", tag), mem_w_addr, 0);
      chk($sformatf("%s w_data", tag), mem_w_data, 0);
   endtask
   // rmode: 0 ready always high, 1 random ready, 2 ready low for cycles 3..7
   task automatic dump(input logic [W-1:0] b, input logic [W-1:0] l, input int rmode,
                       input string tag, output int done_cyc);
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      int         words;
      int         dones;
      logic       stall;
      logic [7:0] held;
      words = int'(W'(l - b)) + 1;
      for (int i = 0; i < words; i++) begin
         logic [B-1:0] w;
         w = model[W'(int'(b) + i)];
         for (int k = 0; k < B / 8; k++) exp_q.push_back(w[8*k +: 8]);
      end
      dones = 0;
      done_cyc = -1;
      stall = 0;
      held = 0;
      base_addr = b;
      last_addr = l;
      start = 1;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(negedge clk);
         start = 0;
         clear_start = 0;
         if (stall) begin
            chk($sformatf("%s hold valid", tag), tx_valid, 1);
            chk($sformatf("%s hold data", tag), tx_data, held);
         end
         tx_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : !(cyc >= 3 && cyc <= 7);
         stall = tx_valid && !tx_ready;
         held = tx_data;
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
         if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc > done_cyc) break;
      end
      chk($sformatf("%s done count", tag), dones, 1);
      chk($sformatf("%s busy after", tag), busy, 0);
      chk($sformatf("%s byte count", tag), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s byte %0d", tag, i), got_q[i], exp_q[i]);
   endtask
   initial begin
      int dc;
      int dones;
      model_reset();
      repeat (3) @(negedge clk);
      check_idle("in reset");
      reset = 0;
      reload = 0;
      @(negedge clk);
      check_idle("after reset");
      dump(4'd3, 4'd3, 0, "single", dc);
      chk("single latency", dc, 4);
      dump(4'd2, 4'd4, 0, "range", dc);
      chk("range latency", dc, 10);
      dump(4'd14, 4'd1, 0, "wrap", dc);
      chk("wrap latency", dc, 13);
      dump(4'd6, 4'd7, 2, "backpressure", dc);
      tx_ready = 1;
      base_addr = 2;
      last_addr = 6;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      chk("mid byte1 valid", tx_valid, 1);
      chk("mid byte1 data", tx_data, 8'hA0);
      reset = 1;
      @(negedge clk);
      check_idle("abort");
      reset = 0;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("abort no done", dones, 0);
      dump(4'd5, 4'd7, 1, "post abort", dc);
      for (int n = 0; n < 6; n++) dump(W'($urandom), W'($urandom), 1, $sformatf("rand%0d", n), dc);
      clear_start = 1;
      dump(4'd1, 4'd1, 0, "start+clear", dc);
      chk("start+clear no writes", wr_cnt, 0);
`ifdef MEM_DUMP_CLEAR_EN
      begin
         int idx;
         idx = 0;
         dones = 0;
         clear_start = 1;
         for (int cyc = 0; cyc < 100 && dones == 0; cyc++) begin
            @(negedge clk);
            clear_start = 0;
            if (mem_wr_en) begin
               chk($sformatf("clear addr %0d", idx), mem_w_addr, idx);
               chk($sformatf("clear data %0d", idx), mem_w_data, 0);
               idx++;
            end
            if (done) dones++;
         end
         chk("clear writes", idx, 16);
         chk("clear done", dones, 1);
         @(negedge clk);
         chk("clear busy after", busy, 0);
         for (int i = 0; i < 16; i++) model[i] = '0;
         dump(4'd0, 4'd15, 0, "after clear", dc);
         reload = 1;
         @(negedge clk);
         reload = 0;
         model_reset();
         dump(4'd9, 4'd10, 0, "after reload", dc);
      end
`else
      clear_start = 1;
      @(negedge clk);
      clear_start = 0;
      chk("clear ignored busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("clear ignored writes", wr_cnt, 0);
      chk("clear ignored wr_en", mem_wr_en, 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
